// File: rtl/softmax_pkg.sv
// Shared types and width helpers for the softmax row-preparation block.
// Default shape constants mirror the top-level parameter defaults.
package softmax_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        LAST  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_MATRIX_NUM    = 12;
    localparam int DEF_INPUT_SHAPE_1 = 128;
    localparam int DEF_INPUT_SHAPE_2 = 128;

    // Counters for a shape of 1 still need one bit to exist.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_WIDTH  = cnt_width(DEF_INPUT_SHAPE_2);
    localparam int ROW_WIDTH  = cnt_width(DEF_INPUT_SHAPE_1);
    localparam int MAT_WIDTH  = cnt_width(DEF_MATRIX_NUM);
    localparam int DIFF_WIDTH = DEF_DATA_WIDTH + 1;

endpackage

// File: rtl/softmax_row_buf.sv
// One-row score buffer: simple dual-port memory, one write and one read per cycle.
// Read data is registered and appears the cycle after rd_en_i; contents are never reset.
module softmax_row_buf #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_p,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_p) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/softmax_row_prep.sv
// Buffers one score row, finds its maximum, then streams (row_max - x) with row/matrix/frame tags.
// First output 2 cycles after the row's last accept; output register holds while out_ready is low.
module softmax_row_prep
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int MATRIX_NUM    = DEF_MATRIX_NUM,
    parameter int INPUT_SHAPE_1 = DEF_INPUT_SHAPE_1,
    parameter int INPUT_SHAPE_2 = DEF_INPUT_SHAPE_2
) (
    input  logic                  clk_p,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   out_data,
    output logic [DATA_WIDTH-1:0] out_row_max,
    output logic                  out_row_last,
    output logic                  out_mat_last,
    output logic                  out_frame_last
);

    localparam int COL_W  = cnt_width(INPUT_SHAPE_2);
    localparam int ROW_W  = cnt_width(INPUT_SHAPE_1);
    localparam int MAT_W  = cnt_width(MATRIX_NUM);
    localparam int DIFF_W = DATA_WIDTH + 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(INPUT_SHAPE_2 - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(INPUT_SHAPE_1 - 1);
    localparam logic [MAT_W-1:0] MAT_LAST = MAT_W'(MATRIX_NUM - 1);

    state_t state_q, state_d;

    logic [COL_W-1:0]             col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0]             row_cnt_q, row_cnt_d;
    logic [MAT_W-1:0]             mat_cnt_q, mat_cnt_d;
    logic signed [DATA_WIDTH-1:0] run_max_q, run_max_d;
    logic signed [DATA_WIDTH-1:0] row_max_q, row_max_d;
    logic                         rd_done_q, rd_done_d;
    logic                         rd_vld_q, rd_vld_d;
    logic                         rd_last_q, rd_last_d;
    logic                         out_vld_q, out_vld_d;
    logic [DIFF_W-1:0]            out_dat_q, out_dat_d;
    logic [DATA_WIDTH-1:0]        out_max_q, out_max_d;
    logic                         row_last_q, row_last_d;
    logic                         mat_last_q, mat_last_d;
    logic                         frame_last_q, frame_last_d;
    logic                         ready_en_q;

    logic                         in_fire;
    logic                         out_fire;
    logic                         adv;
    logic                         rd_issue;
    logic signed [DATA_WIDTH-1:0] in_sdat;
    logic [DATA_WIDTH-1:0]        buf_rd_dat;

    assign in_sdat  = in_data;
    assign in_ready = ready_en_q && (state_q == FILL);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_vld_q && out_ready;
    // The read stage and output register move together; nothing moves while the output is stalled.
    assign adv      = !out_vld_q || out_ready;
    assign rd_issue = adv && (state_q != FILL) && !rd_done_q;

    softmax_row_buf #(
        .DEPTH (INPUT_SHAPE_2),
        .WIDTH (DATA_WIDTH),
        .AW    (COL_W)
    ) u_row_buf (
        .clk_p     (clk_p),
        .wr_en_i   (in_fire),
        .wr_addr_i (col_cnt_q),
        .wr_data_i (in_data),
        .rd_en_i   (rd_issue),
        .rd_addr_i (col_cnt_q),
        .rd_data_o (buf_rd_dat)
    );

    always_comb begin
        state_d      = state_q;
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        mat_cnt_d    = mat_cnt_q;
        run_max_d    = run_max_q;
        row_max_d    = row_max_q;
        rd_done_d    = rd_done_q;
        rd_vld_d     = rd_vld_q;
        rd_last_d    = rd_last_q;
        out_vld_d    = out_vld_q;
        out_dat_d    = out_dat_q;
        out_max_d    = out_max_q;
        row_last_d   = row_last_q;
        mat_last_d   = mat_last_q;
        frame_last_d = frame_last_q;

        unique case (state_q)
            FILL: begin
                if (in_fire) begin
                    if ((col_cnt_q == '0) || (in_sdat > run_max_q)) begin
                        run_max_d = in_sdat;
                    end
                    if (col_cnt_q == COL_LAST) begin
                        col_cnt_d = '0;
                        state_d   = LAST;
                    end else begin
                        col_cnt_d = col_cnt_q + COL_W'(1);
                    end
                end
            end
            LAST: begin
                row_max_d = run_max_q;
                state_d   = DRAIN;
            end
            DRAIN: begin
                if (out_fire && row_last_q) begin
                    state_d   = FILL;
                    rd_done_d = 1'b0;
                    if (row_cnt_q == ROW_LAST) begin
                        row_cnt_d = '0;
                        mat_cnt_d = (mat_cnt_q == MAT_LAST) ? '0 : mat_cnt_q + MAT_W'(1);
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_W'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase

        // During LAST/DRAIN col_cnt is the read address; it wraps back to 0 ready for the next fill.
        if (rd_issue) begin
            col_cnt_d = (col_cnt_q == COL_LAST) ? '0 : col_cnt_q + COL_W'(1);
            rd_done_d = (col_cnt_q == COL_LAST);
        end

        if (adv) begin
            rd_vld_d  = rd_issue;
            rd_last_d = rd_issue && (col_cnt_q == COL_LAST);
            out_vld_d = rd_vld_q;
            if (rd_vld_q) begin
                out_dat_d    = {row_max_q[DATA_WIDTH-1], row_max_q}
                             - {buf_rd_dat[DATA_WIDTH-1], buf_rd_dat};
                out_max_d    = row_max_q;
                row_last_d   = rd_last_q;
                mat_last_d   = rd_last_q && (row_cnt_q == ROW_LAST);
                frame_last_d = rd_last_q && (row_cnt_q == ROW_LAST) && (mat_cnt_q == MAT_LAST);
            end else begin
                row_last_d   = 1'b0;
                mat_last_d   = 1'b0;
                frame_last_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            mat_cnt_q    <= '0;
            run_max_q    <= '0;
            row_max_q    <= '0;
            rd_done_q    <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            out_vld_q    <= 1'b0;
            out_dat_q    <= '0;
            out_max_q    <= '0;
            row_last_q   <= 1'b0;
            mat_last_q   <= 1'b0;
            frame_last_q <= 1'b0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            mat_cnt_q    <= mat_cnt_d;
            run_max_q    <= run_max_d;
            row_max_q    <= row_max_d;
            rd_done_q    <= rd_done_d;
            rd_vld_q     <= rd_vld_d;
            rd_last_q    <= rd_last_d;
            out_vld_q    <= out_vld_d;
            out_dat_q    <= out_dat_d;
            out_max_q    <= out_max_d;
            row_last_q   <= row_last_d;
            mat_last_q   <= mat_last_d;
            frame_last_q <= frame_last_d;
            ready_en_q   <= 1'b1;
        end
    end

    assign out_valid      = out_vld_q;
    assign out_data       = out_dat_q;
    assign out_row_max    = out_max_q;
    assign out_row_last   = row_last_q;
    assign out_mat_last   = mat_last_q;
    assign out_frame_last = frame_last_q;

endmodule

// File: tb/tb_softmax_row_prep.sv
// Self-checking bench for softmax_row_prep: a row-level reference model feeds a scoreboard
// that checks every output transfer, plus literal checks on captured rows.
module tb_softmax_row_prep;

    localparam int DW  = 8;
    localparam int DW1 = DW + 1;
    localparam int MN  = 3;
    localparam int S1  = 4;
    localparam int S2  = 128;

    typedef struct packed {
        logic [DW:0]   d;
        logic [DW-1:0] m;
        logic [2:0]    fl;
    } exp_t;

    logic          clk_p    = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW:0]   out_data;
    logic [DW-1:0] out_row_max;
    logic          out_row_last;
    logic          out_mat_last;
    logic          out_frame_last;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int rows_done = 0;
    int mats_seen = 0;
    int frames_seen = 0;
    int row_i = 0;
    int mat_i = 0;
    bit stall_mode = 1'b0;
    int stall_left = 0;
    int cap_i = 0;

    exp_t          exp_q[$];
    logic [DW-1:0] rowv    [S2];
    logic [DW:0]   cap_dat [S2];
    logic [DW-1:0] cap_max [S2];
    logic          cap_rl  [S2];

    softmax_row_prep #(
        .DATA_WIDTH    (DW),
        .MATRIX_NUM    (MN),
        .INPUT_SHAPE_1 (S1),
        .INPUT_SHAPE_2 (S2)
    ) dut (
        .clk_p          (clk_p),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_row_max    (out_row_max),
        .out_row_last   (out_row_last),
        .out_mat_last   (out_mat_last),
        .out_frame_last (out_frame_last)
    );

    always #5 clk_p = ~clk_p;
    always @(posedge clk_p) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Downstream ready: always 1, or random stalls of 0..5 cycles between accepts.
    always @(posedge clk_p) begin
        #1;
        if (!stall_mode || stall_left == 0) begin
            out_ready  = 1'b1;
            stall_left = stall_mode ? int'($urandom_range(0, 5)) : 0;
        end else begin
            out_ready  = 1'b0;
            stall_left = stall_left - 1;
        end
    end

    // Scoreboard, sampled on the falling edge.
    logic          prev_vld   = 1'b0;
    logic          stall_prev = 1'b0;
    logic          exp_rdy    = 1'b0;
    logic [2*DW+4:0] snap     = '0;
    exp_t          e_cur;

    always @(negedge clk_p) begin
        if (!rst_n) begin
            prev_vld   = 1'b0;
            stall_prev = 1'b0;
            exp_rdy    = 1'b0;
            cap_i      = 0;
        end else begin
            if (exp_rdy) chk("in_ready_after_row", 64'(in_ready), 64'(1));
            exp_rdy = 1'b0;
            if (stall_prev)
                chk("stall_hold", 64'({out_valid, out_data, out_row_max, out_row_last,
                                       out_mat_last, out_frame_last}), 64'(snap));
            if (!out_valid)
                chk("flags_idle", 64'({out_row_last, out_mat_last, out_frame_last}), 64'(0));
            else
                chk("in_ready_drain", 64'(in_ready), 64'(0));
            if (out_valid && !prev_vld)
                chk("first_out_latency", 64'(cyc - last_acc_cyc), 64'(2));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'(exp_q.size()), 64'(1));
                end else begin
                    e_cur = exp_q.pop_front();
                    chk("out_data", 64'(out_data), 64'(e_cur.d));
                    chk("out_row_max", 64'(out_row_max), 64'(e_cur.m));
                    chk("out_flags", 64'({out_row_last, out_mat_last, out_frame_last}), 64'(e_cur.fl));
                end
                if (cap_i < S2) begin
                    cap_dat[cap_i] = out_data;
                    cap_max[cap_i] = out_row_max;
                    cap_rl[cap_i]  = out_row_last;
                end
                if (out_mat_last)   mats_seen++;
                if (out_frame_last) frames_seen++;
                if (out_row_last) begin
                    rows_done++;
                    cap_i   = 0;
                    exp_rdy = 1'b1;
                end else begin
                    cap_i++;
                end
            end
            stall_prev = out_valid && !out_ready;
            snap       = {out_valid, out_data, out_row_max, out_row_last, out_mat_last, out_frame_last};
            prev_vld   = out_valid;
        end
    end

    // Reference model: whole-row max and distances, tags from the row/matrix position.
    task automatic push_model();
        int   mx;
        exp_t e;
        mx = int'($signed(rowv[0]));
        for (int j = 1; j < S2; j++)
            if (int'($signed(rowv[j])) > mx) mx = int'($signed(rowv[j]));
        for (int j = 0; j < S2; j++) begin
            e.d     = DW1'(mx - int'($signed(rowv[j])));
            e.m     = DW'(mx);
            e.fl[2] = (j == S2 - 1);
            e.fl[1] = e.fl[2] && (row_i == S1 - 1);
            e.fl[0] = e.fl[1] && (mat_i == MN - 1);
            exp_q.push_back(e);
        end
        if (row_i == S1 - 1) begin
            row_i = 0;
            mat_i = (mat_i == MN - 1) ? 0 : mat_i + 1;
        end else begin
            row_i++;
        end
    endtask

    task automatic send_elems(input int n);
        for (int j = 0; j < n; j++) begin
            int t;
            t        = 0;
            in_valid = 1'b1;
            in_data  = rowv[j];
            while (!in_ready && t < 4000) begin
                @(negedge clk_p);
                t++;
            end
            if (t >= 4000) chk("in_ready_timeout", 64'(t), 64'(0));
            @(negedge clk_p);
            last_acc_cyc = cyc;
        end
        in_valid = 1'b0;
        in_data  = DW'($urandom);
    endtask

    task automatic drive_row();
        send_elems(S2);
        push_model();
    endtask

    task automatic wait_rows(input int target);
        int t;
        t = 0;
        while (rows_done < target && t < 5000) begin
            @(negedge clk_p);
            t++;
        end
        chk("rows_drained", 64'(rows_done), 64'(target));
    endtask

    task automatic do_reset();
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_async_out", 64'({out_valid, out_data, out_row_max, out_row_last,
                                  out_mat_last, out_frame_last}), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        exp_q.delete();
        row_i = 0;
        mat_i = 0;
        @(negedge clk_p);
        #2;
        rst_n = 1'b1;
        @(negedge clk_p);
        chk("in_ready_after_release", 64'(in_ready), 64'(1));
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int base, bm, bf, diffs, nrl, t;
        logic [DW:0]   ref_dat [S2];
        logic [DW-1:0] ref_max [S2];

        #3;
        chk("reset_out", 64'({out_valid, out_data, out_row_max, out_row_last,
                              out_mat_last, out_frame_last}), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk_p);
        @(negedge clk_p);
        #2;
        rst_n = 1'b1;
        @(negedge clk_p);
        chk("in_ready_first_edge", 64'(in_ready), 64'(1));

        // Row of all 5.
        base = rows_done;
        for (int j = 0; j < S2; j++) rowv[j] = DW'(5);
        drive_row();
        wait_rows(base + 1);
        diffs = 0;
        nrl   = 0;
        for (int j = 0; j < S2; j++) begin
            if (cap_dat[j] != '0) diffs++;
            if (cap_rl[j]) nrl++;
        end
        chk("all5_nonzero_count", 64'(diffs), 64'(0));
        chk("all5_row_max", 64'(cap_max[0]), 64'(5));
        chk("all5_row_last_count", 64'(nrl), 64'(1));
        chk("all5_row_last_pos", 64'(cap_rl[S2-1]), 64'(1));

        // Ramp -128..-1.
        base = rows_done;
        for (int j = 0; j < S2; j++) rowv[j] = DW'(j - 128);
        drive_row();
        wait_rows(base + 1);
        chk("ramp_first", 64'(cap_dat[0]), 64'(127));
        chk("ramp_mid", 64'(cap_dat[64]), 64'(63));
        chk("ramp_last", 64'(cap_dat[S2-1]), 64'(0));
        chk("ramp_row_max", 64'(cap_max[10]), 64'(8'hFF));

        // Extremes: -128 and 127 among zeros.
        base = rows_done;
        for (int j = 0; j < S2; j++) rowv[j] = '0;
        rowv[10]  = 8'h80;
        rowv[100] = 8'h7F;
        drive_row();
        wait_rows(base + 1);
        chk("ext_min_pos", 64'(cap_dat[10]), 64'(255));
        chk("ext_zero_pos", 64'(cap_dat[0]), 64'(127));
        chk("ext_max_pos", 64'(cap_dat[100]), 64'(0));
        chk("ext_row_max", 64'(cap_max[50]), 64'(127));

        // Same random row without and with output stalls.
        base = rows_done;
        for (int j = 0; j < S2; j++) rowv[j] = DW'($urandom);
        drive_row();
        wait_rows(base + 1);
        for (int j = 0; j < S2; j++) begin
            ref_dat[j] = cap_dat[j];
            ref_max[j] = cap_max[j];
        end
        stall_mode = 1'b1;
        drive_row();
        wait_rows(base + 2);
        stall_mode = 1'b0;
        diffs = 0;
        for (int j = 0; j < S2; j++)
            if (cap_dat[j] !== ref_dat[j] || cap_max[j] !== ref_max[j]) diffs++;
        chk("stall_vs_unstalled", 64'(diffs), 64'(0));

        // Reset at element 60 of row 3, then mid-drain.
        do_reset();
        base = rows_done;
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < S2; j++) rowv[j] = DW'($urandom);
            drive_row();
        end
        for (int j = 0; j < S2; j++) rowv[j] = DW'($urandom);
        send_elems(60);
        wait_rows(base + 3);
        do_reset();
        for (int j = 0; j < S2; j++) rowv[j] = DW'($urandom);
        drive_row();
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk_p);
            t++;
        end
        chk("drain_started", 64'(out_valid), 64'(1));
        repeat (20) @(negedge clk_p);
        do_reset();
        base = rows_done;
        bm   = mats_seen;
        for (int r = 0; r < S1; r++) begin
            for (int j = 0; j < S2; j++) rowv[j] = DW'($urandom);
            drive_row();
        end
        wait_rows(base + S1);
        chk("post_reset_mat_last", 64'(mats_seen - bm), 64'(1));

        // Two full frames of random data.
        do_reset();
        base = rows_done;
        bm   = mats_seen;
        bf   = frames_seen;
        for (int r = 0; r < MN * S1; r++) begin
            for (int j = 0; j < S2; j++) rowv[j] = DW'($urandom);
            drive_row();
        end
        wait_rows(base + MN * S1);
        chk("frame1_mat_last", 64'(mats_seen - bm), 64'(MN));
        chk("frame1_frame_last", 64'(frames_seen - bf), 64'(1));
        for (int r = 0; r < MN * S1; r++) begin
            for (int j = 0; j < S2; j++) rowv[j] = DW'($urandom);
            drive_row();
        end
        wait_rows(base + 2 * MN * S1);
        chk("frame2_mat_last", 64'(mats_seen - bm), 64'(2 * MN));
        chk("frame2_frame_last", 64'(frames_seen - bf), 64'(2));

        repeat (4) @(negedge clk_p);
        chk("leftover_expected", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/softmax_row_prep.md
SOFTMAX_ROW_PREP -- requirements
Module: softmax_row_prep

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one signed two's-complement score element.
REQ-002 Parameter MATRIX_NUM, default 12: number of score matrices (heads) per frame.
REQ-003 Parameter INPUT_SHAPE_1, default 128: rows per matrix.
REQ-004 Parameter INPUT_SHAPE_2, default 128: elements per row, with a minimum of 2.
REQ-005 clk_p  input  1  the single clock; all logic is rising-edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  score element present.
REQ-008 in_data  input  DATA_WIDTH  signed score element, row-major.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  downstream softmax stage accepts out_data.
REQ-012 out_data  output  DATA_WIDTH+1  unsigned distance (row_max - x).
REQ-013 out_row_max  output  DATA_WIDTH  signed maximum of the current output row.
REQ-014 out_row_last  output  1  out_data is the last element of a row.
REQ-015 out_mat_last  output  1  out_data is the last element of a matrix.
REQ-016 out_frame_last  output  1  out_data is the last element of matrix MATRIX_NUM-1.

Function
REQ-017 A transfer occurs on either port when valid and ready are both 1 at a rising edge.
REQ-018 The FSM has three states, and reset enters FILL.
  - FILL: in_ready=1. Each accepted element is written to the row buffer at col_cnt, and run_max is updated to max(run_max, in_data).
  - LAST: after the INPUT_SHAPE_2-th accept, the FSM latches row_max and moves to DRAIN on the next cycle.
  - DRAIN: in_ready=0. The buffer is read out in order 0..INPUT_SHAPE_2-1.
REQ-019 run_max is loaded with the first element of each row; no sentinel value is used.
REQ-020 out_data is computed as row_max - x at DATA_WIDTH+1 bits. The result is always ≥0, and the maximum value 2^DATA_WIDTH-1 is reached without saturation.
REQ-021 The first out_valid of a row rises exactly 2 cycles after the accept of the last input element of that row. One cycle is for the FSM transition and one is for the buffer read latency.
REQ-022 With out_ready held at 1, the block outputs one element per cycle, with no bubbles inside a row.
REQ-023 While out_valid=1 and out_ready=0, all out_* signals hold stable and the read address does not advance.
REQ-024 After the accept of the last output of a row, the FSM returns to FILL and in_ready=1 on the next cycle.
REQ-025 The block does not overlap a row's input with the previous row's drain.
REQ-026 col_cnt wraps at INPUT_SHAPE_2, row_cnt wraps at INPUT_SHAPE_1, and mat_cnt wraps at MATRIX_NUM.
REQ-027 After the frame completes, all counters return to 0 and the next frame follows with no idle requirement.
REQ-028 The out_*_last flags are asserted only together with out_valid.
  - out_frame_last implies out_mat_last.
  - out_mat_last implies out_row_last.
REQ-029 in_valid is ignored while in_ready=0. in_data is don't-care when in_valid=0.

Reset
REQ-030 rst_n=0 asynchronously clears the following:
  - the FSM, to FILL;
  - all counters, to 0;
  - run_max and row_max, to 0;
  - out_valid, out_data, out_row_max and all out_*_last, to 0.
REQ-031 in_ready is 0 while rst_n=0, and is 1 from the first clock edge after release.
REQ-032 A reset mid-row or mid-drain discards the partial row. The first element after release is treated as column 0, row 0, matrix 0.
REQ-033 Row buffer contents are not reset.

Structure
REQ-034 The shared package softmax_pkg holds the following:
  - the FSM state enum (FILL, LAST, DRAIN);
  - the width constants: counter widths via $clog2 of each shape parameter, and DIFF_WIDTH = DATA_WIDTH+1.
REQ-035 One sub-module, softmax_row_buf, provides the buffer: a simple dual-port INPUT_SHAPE_2 x DATA_WIDTH memory with a registered (1-cycle) read and no reset.
REQ-036 The FSM, counters, max tracking and output register reside in softmax_row_prep.

Verification
REQ-037 Row of all 5, out_ready=1 -> out_data is 0 for all 128 elements, out_row_max=5, and out_row_last is set on the 128th element only.
REQ-038 Row ramp -128..-1 -> row_max=-1 and out_data=127,126,...,0. The first out_valid occurs 2 cycles after the last accept.
REQ-039 Row containing -128 and 127 (all other elements 0) -> out_data=255 at the -128 position, 127 at the zeros, and 0 at the 127.
REQ-040 Random out_ready stalls of 0-5 cycles -> the output sequence is identical to the unstalled run, out_* are stable during each stall, and in_ready=0 throughout DRAIN.
REQ-041 rst_n pulsed low at input element 60 of row 3 -> outputs clear immediately. The next full row drains correctly with row_cnt=0.
REQ-042 Full frame of 12x128x128 random data -> out_mat_last pulses 12 times, out_frame_last pulses once on the final element, and the counters wrap into a second frame.
